// File: rtl/axis_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | axis_pkg : shared AXI4-Stream defaults and a width helper.   Rev 1.0    |
// +-------------------------------------------------------------------------+
package axis_pkg;

  localparam int AXIS_DATA_W = 32;

  // Ceiling log2, usable in constant expressions; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_tx_fifo.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | axis_tx_fifo : synchronous buffer with occupancy and registered ready.  |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module axis_tx_fifo
  import axis_pkg::*;
#(
  parameter int DATA_W     = AXIS_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push_valid,
  input  logic [DATA_W-1:0]          i_push_data,
  output logic                       o_push_ready,
  input  logic                       i_pop,
  output logic [DATA_W-1:0]          o_head_data,
  output logic [clog2(FIFO_DEPTH):0] o_level
);

  localparam int PTR_W = clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              in_ready_q, in_ready_d;
  logic              w_push;

  always_comb begin
    w_push     = i_push_valid && in_ready_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (i_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({w_push, i_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    // Ready looks at the next occupancy so a same-edge pop reopens the port.
    in_ready_d = (level_d < LVL_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      in_ready_q <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= i_push_data;
  end

  assign o_head_data  = mem_q[rd_ptr_q];
  assign o_level      = level_q;
  assign o_push_ready = in_ready_q;

endmodule
`default_nettype wire

// File: rtl/axis_master_tx.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | axis_master_tx : AXI4-Stream master with FIFO and registered output.    |
// | Optional TLAST framing via AXIS_TX_TLAST_EN.                 Rev 1.0    |
// +-------------------------------------------------------------------------+
module axis_master_tx
  import axis_pkg::*;
#(
  parameter int DATA_W     = AXIS_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int PKT_LEN    = 8
) (
  input  logic                       ACLK,
  input  logic                       ARST,
  input  logic                       IN_VALID,
  input  logic [DATA_W-1:0]          IN_DATA,
  output logic                       IN_READY,
  output logic                       M_TVALID,
  output logic [DATA_W-1:0]          M_TDATA,
`ifdef AXIS_TX_TLAST_EN
  output logic                       M_TLAST,
`endif
  input  logic                       M_TREADY,
  output logic [clog2(FIFO_DEPTH):0] LEVEL
);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (PKT_LEN < 1)) begin : g_param_check
    $error("axis_master_tx: FIFO_DEPTH must be a power of two >= 2 and PKT_LEN >= 1");
  end

  logic              tvalid_q, tvalid_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic [DATA_W-1:0] w_head_data;
  logic              w_free;
  logic              w_pop;

  axis_tx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (ACLK),
    .rst          (ARST),
    .i_push_valid (IN_VALID),
    .i_push_data  (IN_DATA),
    .o_push_ready (IN_READY),
    .i_pop        (w_pop),
    .o_head_data  (w_head_data),
    .o_level      (LEVEL)
  );

  // The output register only depends on registered state and M_TREADY for
  // its next value, so TVALID is never combinational from TREADY.
  always_comb begin
    w_free   = !tvalid_q || M_TREADY;
    w_pop    = w_free && (LEVEL != '0);
    tvalid_d = w_free ? w_pop : tvalid_q;
    tdata_d  = w_pop ? w_head_data : tdata_q;
  end

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
    end else begin
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
    end
  end

  assign M_TVALID = tvalid_q;
  assign M_TDATA  = tdata_q;

`ifdef AXIS_TX_TLAST_EN
  localparam int CNT_W = (PKT_LEN > 1) ? clog2(PKT_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_LEN - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tlast_q, tlast_d;

  always_comb begin
    cnt_d   = cnt_q;
    tlast_d = tlast_q;
    if (w_pop) begin
      tlast_d = (cnt_q == LAST_BEAT);
      cnt_d   = (cnt_q == LAST_BEAT) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      cnt_q   <= '0;
      tlast_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      tlast_q <= tlast_d;
    end
  end

  assign M_TLAST = tlast_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_master_tx.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_axis_master_tx : directed self-checking bench for axis_master_tx.    |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_axis_master_tx;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int PKT    = 8;

  logic              ACLK = 1'b0;
  logic              ARST;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              m_tvalid;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tready;
  logic [2:0]        level;
`ifdef AXIS_TX_TLAST_EN
  logic              m_tlast;
`endif

  int n_cmp = 0;
  int n_err = 0;

  axis_master_tx #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (DEPTH),
    .PKT_LEN    (PKT)
  ) dut (
    .ACLK     (ACLK),
    .ARST     (ARST),
    .IN_VALID (in_valid),
    .IN_DATA  (in_data),
    .IN_READY (in_ready),
    .M_TVALID (m_tvalid),
    .M_TDATA  (m_tdata),
`ifdef AXIS_TX_TLAST_EN
    .M_TLAST  (m_tlast),
`endif
    .M_TREADY (m_tready),
    .LEVEL    (level)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Push n consecutive words with TREADY held high; each word must appear
  // one sample after its push edge, back to back, framed every PKT beats.
  task automatic run_stream(input int n, input logic [31:0] base);
    logic exp_v;
    for (int i = 0; i < n + 4; i++) begin
      in_valid = (i < n);
      in_data  = base + 32'(i);
      tick();
      exp_v = (i >= 1) && (i <= n);
      chk("stream_valid", {31'b0, m_tvalid}, {31'b0, exp_v});
      chk("stream_ready", {31'b0, in_ready}, 32'd1);
      if (exp_v) begin
        chk("stream_data", m_tdata, base + 32'(i - 1));
`ifdef AXIS_TX_TLAST_EN
        chk("stream_last", {31'b0, m_tlast}, {31'b0, (((i - 1) % PKT) == PKT - 1)});
`endif
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] sb[$];
    logic [31:0] prev_data;
    logic        prev_stall;
    int          sent;
    int          got;

    ARST     = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    m_tready = 1'b0;
    repeat (3) tick();
    ARST = 1'b0;
    tick();
    chk("rst_tvalid", {31'b0, m_tvalid}, 32'd0);
    chk("rst_inready", {31'b0, in_ready}, 32'd1);
    chk("rst_level", {29'b0, level}, 32'd0);
    chk("rst_tdata", m_tdata, 32'd0);
`ifdef AXIS_TX_TLAST_EN
    chk("rst_tlast", {31'b0, m_tlast}, 32'd0);
`endif

    // Two-cycle latency of a single word.
    m_tready = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hA5A5_0001;
    tick();
    in_valid = 1'b0;
    chk("lat_n_tvalid", {31'b0, m_tvalid}, 32'd0);
    chk("lat_n_level", {29'b0, level}, 32'd1);
    tick();
    chk("lat_n1_tvalid", {31'b0, m_tvalid}, 32'd1);
    chk("lat_n1_tdata", m_tdata, 32'hA5A5_0001);
    chk("lat_n1_level", {29'b0, level}, 32'd0);
    tick();
    chk("lat_done_tvalid", {31'b0, m_tvalid}, 32'd0);

    // Fill under backpressure: one word in the output register, four buffered.
    m_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("fill_ready", {31'b0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_data  = 32'hB000_0000 + 32'(k);
      tick();
    end
    chk("full_ready", {31'b0, in_ready}, 32'd0);
    chk("full_level", {29'b0, level}, 32'd4);
    chk("full_tvalid", {31'b0, m_tvalid}, 32'd1);
    chk("full_tdata", m_tdata, 32'hB000_0000);
    in_data = 32'hDEAD_BEEF;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("stall_tdata", m_tdata, 32'hB000_0000);
      chk("stall_tvalid", {31'b0, m_tvalid}, 32'd1);
    end
    in_valid = 1'b0;
    chk("stall_level", {29'b0, level}, 32'd4);
    m_tready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      tick();
      chk("drain_tdata", m_tdata, 32'hB000_0000 + 32'(j));
      chk("drain_level", {29'b0, level}, 32'(4 - j));
      chk("drain_ready", {31'b0, in_ready}, 32'd1);
    end
    tick();
    chk("drain_empty", {31'b0, m_tvalid}, 32'd0);

    // Restart framing from beat 0, then a continuous 16-word stream.
    ARST = 1'b1;
    tick();
    ARST = 1'b0;
    run_stream(16, 32'd0);

    // Random backpressure with a scoreboard and AXI stability checks.
    sent       = 0;
    got        = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int cyc = 0; cyc < 4000 && got < 200; cyc++) begin
      if (prev_stall) begin
        chk("hold_tvalid", {31'b0, m_tvalid}, 32'd1);
        chk("hold_tdata", m_tdata, prev_data);
      end
      m_tready = 1'($urandom_range(0, 1));
      if (m_tvalid && m_tready) begin
        if (sb.size() == 0) begin
          chk("order_underflow", 32'(sb.size()), 32'd1);
        end else begin
          chk("order_data", m_tdata, sb.pop_front());
        end
        got++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      in_valid   = (sent < 200) && ($urandom_range(0, 3) != 0);
      in_data    = $urandom;
      if (in_valid && in_ready) begin
        sb.push_back(in_data);
        sent++;
      end
      tick();
    end
    in_valid = 1'b0;
    m_tready = 1'b1;
    chk("rand_count", 32'(got), 32'd200);
    chk("rand_leftover", 32'(sb.size()), 32'd0);
    repeat (3) tick();
    chk("rand_idle", {31'b0, m_tvalid}, 32'd0);

    // Reset with the output register and three FIFO entries occupied.
    m_tready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 32'hC000_0000 + 32'(k);
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_tvalid", {31'b0, m_tvalid}, 32'd1);
    chk("pre_rst_level", {29'b0, level}, 32'd3);
    ARST = 1'b1;
    tick();
    chk("mid_rst_tvalid", {31'b0, m_tvalid}, 32'd0);
    chk("mid_rst_level", {29'b0, level}, 32'd0);
    chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
    ARST     = 1'b0;
    m_tready = 1'b1;
    run_stream(8, 32'h0000_0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axis_master_tx.md
# axis_master_tx

AXI4-Stream transmitter (master end) for the 32-bit stream links in the AXI4 protocol block set. It accepts words from a local producer through a valid/ready load port and buffers them in a small FIFO. It drives them onto the stream with a fully registered TVALID/TDATA and optional TLAST packet framing. It is the counterpart that feeds the existing stream receiver.

## Interface
- DATA_W, 32: stream data width.
- FIFO_DEPTH, 4: buffer entries. Must be a power of two, ≥2.
- PKT_LEN, 8: beats per packet for TLAST framing. Must be ≥1.
- ACLK  in  1: single clock; all logic on its rising edge.
- ARST  in  1: reset, synchronous, active-high.
- IN_VALID  in  1: producer offers IN_DATA.
- IN_DATA  in  DATA_W: word to transmit.
- IN_READY  out  1: buffer can accept a word. Registered.
- M_TVALID  out  1: stream beat valid.
- M_TDATA  out  DATA_W: stream beat data.
- M_TREADY  in  1: downstream ready.
- M_TLAST  out  1: last beat of packet. Present only with AXIS_TX_TLAST_EN.
- LEVEL  out  clog2(FIFO_DEPTH)+1: FIFO occupancy. Excludes the output register.

## Operation
- Push: IN_VALID && IN_READY at an edge writes IN_DATA at the write pointer. The write pointer increments and wraps modulo FIFO_DEPTH.
- Output register (M_TDATA/M_TVALID/M_TLAST) is "free" when M_TVALID=0 or M_TVALID && M_TREADY.
- Pop: when the register is free and LEVEL>0, the FIFO head loads into M_TDATA and M_TVALID is set to 1. The read pointer increments and wraps.
- When the register is free and LEVEL=0: M_TVALID←0; M_TDATA holds its last value.
- There is no bypass. A word always passes through the FIFO.
- LEVEL: +1 on push only, −1 on pop only, unchanged on push and pop together.
- IN_READY←(next LEVEL < FIFO_DEPTH). Registered, so it is never combinational from IN_VALID.
- Framing counter (0..PKT_LEN−1) advances on every pop. The popped word gets M_TLAST=1 when the counter equals PKT_LEN−1, and the counter then wraps to 0. PKT_LEN=1 sets TLAST on every beat.
- Reset values: M_TVALID=0, M_TDATA=0, M_TLAST=0, IN_READY=1, LEVEL=0, pointers and counter 0.
- Reset mid-operation: buffered and in-flight words are discarded with no TLAST flush, and the next packet starts at beat 0.

## Timing
- Latency: a push at edge N gives M_TVALID=1 with that word in the cycle after edge N+1, i.e. 2 cycles minimum.
- Throughput: 1 beat/cycle sustained while M_TREADY=1 and the producer keeps up.
- AXI rules:
  - Once M_TVALID=1, M_TDATA and M_TLAST hold until the handshake edge.
  - M_TVALID never depends on M_TREADY in the same cycle.
  - M_TVALID never drops without a handshake.
- Full: IN_READY=0 while LEVEL=FIFO_DEPTH. A pop at edge N raises IN_READY after edge N.
- Empty: LEVEL=0 and a handshake at edge N drops M_TVALID after N. This holds even if a push lands at N.
- Simultaneous push and pop at FIFO_DEPTH−1 keeps IN_READY=1.

## Configuration
- AXIS_TX_TLAST_EN defined: the M_TLAST port and framing counter exist as above.
- AXIS_TX_TLAST_EN undefined: no M_TLAST port and no counter. The stream is unframed. PKT_LEN is ignored.

## Structure
- Shared package axis_pkg holds the AXIS_DATA_W default (32) and the framing counter width function clog2.
- One sub-module, axis_tx_fifo: synchronous FIFO with pointers, LEVEL, and the registered IN_READY.
- The top holds the output register and framing counter.

## Test plan
- After reset release, M_TVALID=0, IN_READY=1, LEVEL=0. Push 0xA5A5_0001 with M_TREADY=1: it appears with M_TVALID=1 exactly 2 cycles after the push edge and accepts after 1 beat.
- Hold M_TREADY=0 and push 5 words (DEPTH=4): 1 word sits in the output register and 4 in the FIFO, IN_READY=0, LEVEL=4. M_TDATA stays stable for 20 cycles.
- Continuous push of 0..15 with M_TREADY=1 (PKT_LEN=8): 16 beats in order at 1/cycle, with M_TLAST=1 on values 7 and 15 only.
- Random M_TREADY over 200 words: output order and count match the input, and no TVALID drop or TDATA change occurs without a handshake.
- Assert ARST with 3 words buffered and TVALID=1: next cycle M_TVALID=0 and LEVEL=0. The next packet's TLAST falls on its 8th beat.
- With AXIS_TX_TLAST_EN undefined, rerun the continuous-push scenario: the same data order, with no M_TLAST port present.
